operand2_shifter: RTL and testbench
===================================

// Module: operand2_shifter
// PURPOSE
//  Iterative ARM operand-2 shifter sitting directly upstream of the ALU.
//  - Builds the shifted-register or rotated-immediate second operand; result drives the ALU RIGHT_OP.
//  - Produces the shifter carry-out used as the C flag for logical ops.
//  - Multi-cycle: moves STEP bit positions per clock under a START/BUSY/DONE handshake.
// PARAMETERS
//  WIDTH  32  datapath width; only 32 is supported.
//  STEP   1   bit positions shifted per RUN cycle; legal values 1, 2, 4, 8.
// PORTS
//  CLK         in   1   clock; all state updates on rising edge.
//  RESET       in   1   asynchronous, active-high reset.
//  START       in   1   request; sampled when BUSY=0.
//  IMM_MODE    in   1   1: rotated immediate; 0: shifted register.
//  REG_AMT     in   1   1: amount = RS_VAL; 0: amount = SHAMT (ignored if IMM_MODE).
//  SH_TYPE     in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR.
//  RM          in   32  value to shift.
//  RS_VAL      in   8   register-specified amount, Rs[7:0].
//  SHAMT       in   5   immediate shift amount.
//  IMM8        in   8   immediate byte.
//  ROT4        in   4   immediate rotate field; rotate right by 2*ROT4.
//  CIN         in   1   current C flag.
//  BUSY        out  1   high while in RUN.
//  DONE        out  1   one-cycle pulse; SHIFT_OUT/SHIFT_COUT valid.
//  SHIFT_OUT   out  32  result; held until the next accepted START.
//  SHIFT_COUT  out  1   shifter carry-out; held with SHIFT_OUT.
// BEHAVIOUR
//  Reset and state machine:
//  - Reset: state=IDLE; BUSY=0, DONE=0, SHIFT_OUT=0, SHIFT_COUT=0.
//  - States IDLE, RUN, FIN. START is accepted in IDLE or FIN, never in RUN; START during RUN is ignored.
//  - On accept, operands are latched and count n is normalised:
//    -> RUN if n>0; -> FIN if n=0.
//  - RUN: shift by min(STEP, remaining) per cycle; -> FIN when remaining reaches 0.
//  - FIN: DONE=1, BUSY=0; -> IDLE, or straight to RUN/FIN if START is present.
//  Latency:
//  - Latency = 1 + ceil(n/STEP) cycles from the START edge to DONE.
//  Register amount (REG_AMT=1, a=RS_VAL):
//  - a=0: out=RM, cout=CIN.
//  - LSL/LSR: n=min(a,33). This gives a=32 -> out 0, cout RM[0] (LSL) / RM[31] (LSR), and a>32 -> out 0, cout 0.
//  - ASR: n=min(a,32). a>=32 -> out all RM[31], cout RM[31].
//  - ROR: n=a[4:0]. If a[4:0]=0 and a!=0: out=RM, cout=RM[31], n=0.
//  Immediate amount (REG_AMT=0, a=SHAMT):
//  - LSL #0: out=RM, cout=CIN.
//  - LSR #0 means LSR #32; ASR #0 means ASR #32.
//  - ROR #0 means RRX: n=1; out={CIN,RM[31:1]}, cout=RM[0].
//  Immediate mode:
//  - Operand is {24'b0,IMM8} rotated right by n=2*ROT4.
//  - cout = CIN if ROT4=0, else out[31].
//  Carry and rotate rules:
//  - Each shift step updates carry with the last bit shifted out.
//  - ROR/immediate wrap bits from LSB to MSB.
//  Boundary:
//  - RESET mid-RUN aborts immediately: no DONE, outputs return to 0.
//  - Inputs other than START are don't-care after acceptance.
// CONFIGURATION
//  FAST_ROTATE_EN:
//  - Defined: ROR, RRX and immediate-mode ops compute in one combinational rotate at accept.
//    They go straight to FIN, so latency is 1 cycle.
//  - LSL/LSR/ASR stay iterative.
//  - Undefined: all ops are iterative per the latency rule above.
// TESTING
//  (STEP=1, FAST_ROTATE_EN undefined unless noted)
//  1. LSL #1, RM=0x80000001 -> SHIFT_OUT=0x00000002, COUT=1, DONE 2 cycles after START.
//  2. LSR reg, RS_VAL=32, RM=0x80000000 -> 0x00000000, COUT=1, DONE after 33 cycles.
//     RS_VAL=40 -> 0, COUT=0.
//  3. ASR #0 (=#32), RM=0x80000000 -> 0xFFFFFFFF, COUT=1.
//     ROR #0 (RRX), CIN=1, RM=0x00000003 -> 0x80000001, COUT=1.
//  4. IMM8=0xFF, ROT4=4 -> 0xFF000000, COUT=1, latency 9.
//     ROT4=0, CIN=0 -> 0x000000FF, COUT=0.
//     With FAST_ROTATE_EN both cases have latency 1.
//  5. START pulsed again mid-RUN -> ignored, first result unchanged.
//     START in the FIN cycle -> accepted back-to-back.
//  6. RESET asserted at RUN cycle 5 of LSL #20 -> BUSY=0, outputs 0, no DONE.
//     Next op completes normally.

Source files
------------

// File: rtl/operand2_shifter.sv
// Iterative ARM operand-2 shifter feeding the ALU right operand and shifter carry.
// Optional FAST_ROTATE_EN: ROR/RRX/immediate rotates resolve in one cycle at accept.
module operand2_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             IMM_MODE,
  input  logic             REG_AMT,
  input  logic [1:0]       SH_TYPE,
  input  logic [WIDTH-1:0] RM,
  input  logic [7:0]       RS_VAL,
  input  logic [4:0]       SHAMT,
  input  logic [7:0]       IMM8,
  input  logic [3:0]       ROT4,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SHIFT_OUT,
  output logic             SHIFT_COUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  typedef enum logic [2:0] {
    OP_LSL,
    OP_LSR,
    OP_ASR,
    OP_ROR,
    OP_RRX
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             carry_q, carry_d;
  logic [5:0]       rem_q, rem_d;

  op_e              ld_op;
  logic [WIDTH-1:0] ld_val;
  logic             ld_c;
  logic [5:0]       ld_n;

  logic [WIDTH-1:0] st_val;
  logic [WIDTH-1:0] pv;
  logic             st_c;
  logic [5:0]       st_rem;

  logic             accept;

  assign accept     = START && (state_q != S_RUN);
  assign BUSY       = (state_q == S_RUN);
  assign DONE       = (state_q == S_FIN);
  assign SHIFT_OUT  = val_q;
  assign SHIFT_COUT = carry_q;

  // Normalise the request into (op, start value, start carry, step count)
  always_comb begin
    ld_op  = OP_LSL;
    ld_val = RM;
    ld_c   = CIN;
    ld_n   = '0;
    if (IMM_MODE) begin
      ld_op  = OP_ROR;
      ld_val = {{(WIDTH-8){1'b0}}, IMM8};
      ld_n   = {1'b0, ROT4, 1'b0};
    end else if (REG_AMT) begin
      if (RS_VAL != 8'd0) begin
        unique case (SH_TYPE)
          2'b00: begin
            ld_op = OP_LSL;
            ld_n  = (RS_VAL > 8'd33) ? 6'd33 : RS_VAL[5:0];
          end
          2'b01: begin
            ld_op = OP_LSR;
            ld_n  = (RS_VAL > 8'd33) ? 6'd33 : RS_VAL[5:0];
          end
          2'b10: begin
            ld_op = OP_ASR;
            ld_n  = (RS_VAL > 8'd32) ? 6'd32 : RS_VAL[5:0];
          end
          2'b11: begin
            ld_op = OP_ROR;
            ld_n  = {1'b0, RS_VAL[4:0]};
            if (RS_VAL[4:0] == 5'd0) ld_c = RM[WIDTH-1];
          end
        endcase
      end
    end else begin
      unique case (SH_TYPE)
        2'b00: begin
          ld_op = OP_LSL;
          ld_n  = {1'b0, SHAMT};
        end
        2'b01: begin
          ld_op = OP_LSR;
          ld_n  = (SHAMT == 5'd0) ? 6'd32 : {1'b0, SHAMT};
        end
        2'b10: begin
          ld_op = OP_ASR;
          ld_n  = (SHAMT == 5'd0) ? 6'd32 : {1'b0, SHAMT};
        end
        2'b11: begin
          if (SHAMT == 5'd0) begin
            ld_op = OP_RRX;
            ld_n  = 6'd1;
          end else begin
            ld_op = OP_ROR;
            ld_n  = {1'b0, SHAMT};
          end
        end
      endcase
    end
  end

`ifdef FAST_ROTATE_EN
  logic [WIDTH-1:0] fast_val;
  logic             fast_c;

  always_comb begin
    fast_val = ld_val;
    fast_c   = ld_c;
    if (ld_op == OP_RRX) begin
      fast_val = {CIN, RM[WIDTH-1:1]};
      fast_c   = RM[0];
    end else if (ld_n != 6'd0) begin
      fast_val = (ld_val >> ld_n[4:0]) | (ld_val << (6'd32 - ld_n));
      fast_c   = fast_val[WIDTH-1];
    end
  end
`endif

  // Up to STEP single-bit moves per RUN cycle, each gated on work remaining
  always_comb begin
    st_val = val_q;
    st_c   = carry_q;
    st_rem = rem_q;
    pv     = val_q;
    for (int i = 0; i < STEP; i++) begin
      if (st_rem != 6'd0) begin
        pv = st_val;
        unique case (op_q)
          OP_LSL: begin
            st_c   = pv[WIDTH-1];
            st_val = {pv[WIDTH-2:0], 1'b0};
          end
          OP_LSR: begin
            st_c   = pv[0];
            st_val = {1'b0, pv[WIDTH-1:1]};
          end
          OP_ASR: begin
            st_c   = pv[0];
            st_val = {pv[WIDTH-1], pv[WIDTH-1:1]};
          end
          OP_ROR: begin
            st_c   = pv[0];
            st_val = {pv[0], pv[WIDTH-1:1]};
          end
          OP_RRX: begin
            st_val = {st_c, pv[WIDTH-1:1]};
            st_c   = pv[0];
          end
          default: ;
        endcase
        st_rem = st_rem - 6'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_RUN: begin
        val_d   = st_val;
        carry_d = st_c;
        rem_d   = st_rem;
        if (st_rem == 6'd0) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      op_d    = ld_op;
      val_d   = ld_val;
      carry_d = ld_c;
      rem_d   = ld_n;
      state_d = (ld_n == 6'd0) ? S_FIN : S_RUN;
`ifdef FAST_ROTATE_EN
      if (ld_op == OP_ROR || ld_op == OP_RRX) begin
        val_d   = fast_val;
        carry_d = fast_c;
        rem_d   = '0;
        state_d = S_FIN;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= OP_LSL;
      val_q   <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_operand2_shifter.sv
// Directed self-checking bench for operand2_shifter (STEP=1).
module tb_operand2_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imm_mode;
  logic        reg_amt;
  logic [1:0]  sh_type;
  logic [31:0] rm;
  logic [7:0]  rs_val;
  logic [4:0]  shamt;
  logic [7:0]  imm8;
  logic [3:0]  rot4;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sh_out;
  logic        sh_cout;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic seen;

`ifdef FAST_ROTATE_EN
  localparam int LAT_RRX = 1;
  localparam int LAT_IMM = 1;
  localparam int LAT_ROR4 = 1;
`else
  localparam int LAT_RRX = 2;
  localparam int LAT_IMM = 9;
  localparam int LAT_ROR4 = 5;
`endif

  operand2_shifter #(.WIDTH(32), .STEP(1)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .START     (start),
    .IMM_MODE  (imm_mode),
    .REG_AMT   (reg_amt),
    .SH_TYPE   (sh_type),
    .RM        (rm),
    .RS_VAL    (rs_val),
    .SHAMT     (shamt),
    .IMM8      (imm8),
    .ROT4      (rot4),
    .CIN       (cin),
    .BUSY      (busy),
    .DONE      (done),
    .SHIFT_OUT (sh_out),
    .SHIFT_COUT(sh_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic im, input logic ra, input logic [1:0] ty,
                        input logic [31:0] r, input logic [7:0] rs,
                        input logic [4:0] sa, input logic [7:0] i8,
                        input logic [3:0] r4, input logic c);
    imm_mode = im; reg_amt = ra; sh_type = ty; rm = r;
    rs_val = rs; shamt = sa; imm8 = i8; rot4 = r4; cin = c;
  endtask

  // Count edges from the accepting edge until DONE (bounded)
  task automatic wait_done(output int l);
    l = 1;
    while (!done && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run(input logic im, input logic ra, input logic [1:0] ty,
                     input logic [31:0] r, input logic [7:0] rs,
                     input logic [4:0] sa, input logic [7:0] i8,
                     input logic [3:0] r4, input logic c, output int l);
    @(negedge clk);
    set_in(im, ra, ty, r, rs, sa, i8, r4, c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(l);
  endtask

  task automatic expect_op(input string tag, input logic [31:0] eo,
                           input logic ec, input int el, input int l);
    chk({tag, "_out"}, sh_out, eo);
    chk({tag, "_cout"}, {31'b0, sh_cout}, {31'b0, ec});
    chk({tag, "_lat"}, 32'(l), 32'(el));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_in(0, 0, 2'b00, 32'h0, 8'h0, 5'h0, 8'h0, 4'h0, 0);
    #12;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_out", sh_out, 32'h0);
    chk("rst_cout", {31'b0, sh_cout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 0, 2'b00, 32'h80000001, 8'd0, 5'd1, 8'h0, 4'h0, 0, lat);
    expect_op("lsl1", 32'h00000002, 1'b1, 2, lat);

    run(0, 1, 2'b01, 32'h80000000, 8'd32, 5'd0, 8'h0, 4'h0, 0, lat);
    expect_op("lsr_r32", 32'h0, 1'b1, 33, lat);
    run(0, 1, 2'b01, 32'h80000000, 8'd40, 5'd0, 8'h0, 4'h0, 1, lat);
    expect_op("lsr_r40", 32'h0, 1'b0, 34, lat);

    run(0, 0, 2'b10, 32'h80000000, 8'd0, 5'd0, 8'h0, 4'h0, 0, lat);
    expect_op("asr0", 32'hFFFFFFFF, 1'b1, 33, lat);
    run(0, 0, 2'b11, 32'h00000003, 8'd0, 5'd0, 8'h0, 4'h0, 1, lat);
    expect_op("rrx", 32'h80000001, 1'b1, LAT_RRX, lat);

    run(1, 0, 2'b00, 32'h0, 8'd0, 5'd0, 8'hFF, 4'd4, 0, lat);
    expect_op("imm_r4", 32'hFF000000, 1'b1, LAT_IMM, lat);
    run(1, 0, 2'b00, 32'h0, 8'd0, 5'd0, 8'hFF, 4'd0, 0, lat);
    expect_op("imm_r0", 32'h000000FF, 1'b0, 1, lat);

    run(0, 1, 2'b11, 32'h87654321, 8'd32, 5'd0, 8'h0, 4'h0, 0, lat);
    expect_op("ror_r32", 32'h87654321, 1'b1, 1, lat);
    run(0, 1, 2'b00, 32'h00000005, 8'd0, 5'd0, 8'h0, 4'h0, 1, lat);
    expect_op("lsl_r0", 32'h00000005, 1'b1, 1, lat);
    run(0, 1, 2'b00, 32'h00000001, 8'd32, 5'd0, 8'h0, 4'h0, 0, lat);
    expect_op("lsl_r32", 32'h0, 1'b1, 33, lat);
    run(0, 1, 2'b10, 32'h40000000, 8'd200, 5'd0, 8'h0, 4'h0, 1, lat);
    expect_op("asr_r200", 32'h0, 1'b0, 33, lat);
    run(0, 0, 2'b11, 32'h0000000F, 8'd0, 5'd4, 8'h0, 4'h0, 0, lat);
    expect_op("ror4", 32'hF0000000, 1'b1, LAT_ROR4, lat);

    // START re-pulsed while busy must not disturb the running op
    @(negedge clk);
    set_in(0, 0, 2'b01, 32'h0001FF80, 8'd0, 5'd8, 8'h0, 4'h0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    chk("mid_busy", {31'b0, busy}, 32'h1);
    set_in(0, 0, 2'b00, 32'h0, 8'd0, 5'd1, 8'h0, 4'h0, 1);
    start = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    expect_op("ignore", 32'h000001FF, 1'b1, 9, lat);
    @(posedge clk); #1;
    chk("ignore_idle", {31'b0, busy | done}, 32'h0);

    // Back-to-back: new START during the FIN cycle
    run(0, 0, 2'b00, 32'h00000001, 8'd0, 5'd2, 8'h0, 4'h0, 0, lat);
    expect_op("b2b_a", 32'h00000004, 1'b0, 3, lat);
    set_in(0, 0, 2'b01, 32'h00000006, 8'd0, 5'd1, 8'h0, 4'h0, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'h1);
    wait_done(lat);
    expect_op("b2b_b", 32'h00000003, 1'b0, 2, lat);

    // Reset in RUN cycle 5 of LSL #20
    @(negedge clk);
    set_in(0, 0, 2'b00, 32'hFFFFFFFF, 8'd0, 5'd20, 8'h0, 4'h0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_out", sh_out, 32'h0);
    chk("abort_cout", {31'b0, sh_cout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", {31'b0, seen}, 32'h0);
    run(0, 0, 2'b00, 32'h00000001, 8'd0, 5'd3, 8'h0, 4'h0, 0, lat);
    expect_op("after_rst", 32'h00000008, 1'b0, 4, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
